// File: rtl/accelerator_convolutional_fnn_controller_if.sv
// Operand/activation handshake bundle between the NTM control FSM, the FNN
// sequencer and the MAC/activation datapath.
interface accelerator_convolutional_fnn_controller_if #(
  parameter int unsigned CONTROL_SIZE = 64
);

  logic                    START;
  logic                    READY;
  logic [CONTROL_SIZE-1:0] SIZE_X_IN;
  logic [CONTROL_SIZE-1:0] SIZE_W_IN;
  logic [CONTROL_SIZE-1:0] SIZE_L_IN;
  logic [CONTROL_SIZE-1:0] SIZE_R_IN;
  logic                    ACC_CLEAR;
  logic                    OP_ENABLE;
  logic                    OP_READY;
  logic [1:0]              OP_SEL;
  logic [CONTROL_SIZE-1:0] INDEX_L_OUT;
  logic [CONTROL_SIZE-1:0] INDEX_I_OUT;
  logic [CONTROL_SIZE-1:0] INDEX_J_OUT;
  logic                    ACT_ENABLE;
  logic                    ACT_READY;
  logic                    H_OUT_ENABLE;

  // Sequencer side.
  modport master (
    input  START, SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN, OP_READY, ACT_READY,
    output READY, ACC_CLEAR, OP_ENABLE, OP_SEL, INDEX_L_OUT, INDEX_I_OUT, INDEX_J_OUT,
           ACT_ENABLE, H_OUT_ENABLE
  );

  // Control FSM / datapath side.
  modport slave (
    output START, SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN, OP_READY, ACT_READY,
    input  READY, ACC_CLEAR, OP_ENABLE, OP_SEL, INDEX_L_OUT, INDEX_I_OUT, INDEX_J_OUT,
           ACT_ENABLE, H_OUT_ENABLE
  );

endinterface

// File: rtl/accelerator_convolutional_fnn_controller.sv
// Sequencer for the convolutional FNN layer: per hidden output l it streams W*x, K*r and
// bias operands into a shared MAC, runs the activation and emits h(l).
module accelerator_convolutional_fnn_controller #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned X            = 64,
  parameter int unsigned W            = 64,
  parameter int unsigned L            = 64,
  parameter int unsigned R            = 64
) (
  input logic CLK,
  input logic RST,
  accelerator_convolutional_fnn_controller_if.master bus
);

  typedef logic [CONTROL_SIZE-1:0] ctrl_t;

  localparam ctrl_t MaxX = CONTROL_SIZE'(X);
  localparam ctrl_t MaxW = CONTROL_SIZE'(W);
  localparam ctrl_t MaxL = CONTROL_SIZE'(L);
  localparam ctrl_t MaxR = CONTROL_SIZE'(R);
  localparam ctrl_t Zero = '0;
  localparam ctrl_t One  = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  // DATA_SIZE only sizes the datapath buses that accompany the index ports.
  if (DATA_SIZE == 0) begin : g_no_data_width
  end

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMacX,
    StMacR,
    StBias,
    StActivate,
    StEmit
  } state_e;

  state_e state_q, state_d;
  ctrl_t  size_x_q, size_x_d;
  ctrl_t  size_w_q, size_w_d;
  ctrl_t  size_l_q, size_l_d;
  ctrl_t  size_r_q, size_r_d;
  ctrl_t  l_q, l_d;
  ctrl_t  x_q, x_d;
  ctrl_t  i_q, i_d;
  ctrl_t  k_q, k_d;
  logic   ready_q, ready_d;

  function automatic ctrl_t clamp(input ctrl_t v, input ctrl_t m);
    return (v > m) ? m : v;
  endfunction

  ctrl_t lat_x, lat_w, lat_l, lat_r;
  logic  skip_r;

  assign lat_x  = clamp(bus.SIZE_X_IN, MaxX);
  assign lat_w  = clamp(bus.SIZE_W_IN, MaxW);
  assign lat_l  = clamp(bus.SIZE_L_IN, MaxL);
  assign lat_r  = clamp(bus.SIZE_R_IN, MaxR);
  // The K*r phase has no operands when either loop bound is empty.
  assign skip_r = (size_r_q == Zero) || (size_w_q == Zero);

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_w_d = size_w_q;
    size_l_d = size_l_q;
    size_r_d = size_r_q;
    l_d      = l_q;
    x_d      = x_q;
    i_d      = i_q;
    k_d      = k_q;
    ready_d  = 1'b0;

    bus.ACC_CLEAR    = 1'b0;
    bus.OP_ENABLE    = 1'b0;
    bus.OP_SEL       = 2'd0;
    bus.INDEX_I_OUT  = Zero;
    bus.INDEX_J_OUT  = Zero;
    bus.ACT_ENABLE   = 1'b0;
    bus.H_OUT_ENABLE = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.START) begin
          size_x_d = lat_x;
          size_w_d = lat_w;
          size_l_d = lat_l;
          size_r_d = lat_r;
          l_d      = Zero;
          if (lat_l == Zero) begin
            ready_d = 1'b1;
          end else begin
            state_d = StClear;
          end
        end
      end
      StClear: begin
        bus.ACC_CLEAR = 1'b1;
        x_d = Zero;
        i_d = Zero;
        k_d = Zero;
        if (size_x_q != Zero) begin
          state_d = StMacX;
        end else if (skip_r) begin
          state_d = StBias;
        end else begin
          state_d = StMacR;
        end
      end
      StMacX: begin
        bus.OP_ENABLE   = 1'b1;
        bus.OP_SEL      = 2'd0;
        bus.INDEX_J_OUT = x_q;
        if (bus.OP_READY) begin
          if (x_q == size_x_q - One) begin
            state_d = skip_r ? StBias : StMacR;
          end else begin
            x_d = x_q + One;
          end
        end
      end
      StMacR: begin
        bus.OP_ENABLE   = 1'b1;
        bus.OP_SEL      = 2'd1;
        bus.INDEX_I_OUT = i_q;
        bus.INDEX_J_OUT = k_q;
        if (bus.OP_READY) begin
          if (k_q == size_w_q - One) begin
            k_d = Zero;
            if (i_q == size_r_q - One) begin
              state_d = StBias;
            end else begin
              i_d = i_q + One;
            end
          end else begin
            k_d = k_q + One;
          end
        end
      end
      StBias: begin
        bus.OP_ENABLE = 1'b1;
        bus.OP_SEL    = 2'd2;
        if (bus.OP_READY) begin
          state_d = StActivate;
        end
      end
      StActivate: begin
        bus.ACT_ENABLE = 1'b1;
        if (bus.ACT_READY) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        bus.H_OUT_ENABLE = 1'b1;
        if (l_q == size_l_q - One) begin
          state_d = StIdle;
          ready_d = 1'b1;
          l_d     = Zero;
        end else begin
          l_d     = l_q + One;
          state_d = StClear;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.READY       = ready_q;
  assign bus.INDEX_L_OUT = l_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      size_x_q <= Zero;
      size_w_q <= Zero;
      size_l_q <= Zero;
      size_r_q <= Zero;
      l_q      <= Zero;
      x_q      <= Zero;
      i_q      <= Zero;
      k_q      <= Zero;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_x_q <= size_x_d;
      size_w_q <= size_w_d;
      size_l_q <= size_l_d;
      size_r_q <= size_r_d;
      l_q      <= l_d;
      x_q      <= x_d;
      i_q      <= i_d;
      k_q      <= k_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_accelerator_convolutional_fnn_controller.sv
// Scoreboard bench: a layer-level reference model queues the expected event stream and a
// monitor compares every clear/operand/activation/emit/ready event the DUT produces.
module tb_accelerator_convolutional_fnn_controller;

  localparam int unsigned CS = 64;
  localparam int MaxSize = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accelerator_convolutional_fnn_controller_if #(.CONTROL_SIZE(CS)) bus ();

  accelerator_convolutional_fnn_controller #(
    .DATA_SIZE   (64),
    .CONTROL_SIZE(CS),
    .X           (64),
    .W           (64),
    .L           (64),
    .R           (64)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  kind;   // 1 clear, 2 operand, 3 activate, 4 emit, 5 ready
    logic [15:0] l;
    logic [1:0]  sel;
    logic [15:0] i;
    logic [15:0] j;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  hout_count = 0;
  int  xfer_count = 0;
  int  mode       = 0;  // 0 ready inputs tied high, 1 random, 2 driven by directed code

  function automatic ev_t mk(input int kind, input int l, input int sel, input int i,
                             input int j);
    ev_t e;
    e.kind = 4'(kind);
    e.l    = 16'(l);
    e.sel  = 2'(sel);
    e.i    = 16'(i);
    e.j    = 16'(j);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic int clampi(input int v);
    return (v > MaxSize) ? MaxSize : v;
  endfunction

  // Reference model: the event stream of one whole layer evaluation.
  task automatic model_layer(input int sx, input int sw, input int sl, input int sr);
    int x, w, l, r;
    x = clampi(sx);
    w = clampi(sw);
    l = clampi(sl);
    r = clampi(sr);
    for (int e = 0; e < l; e++) begin
      exp_q.push_back(mk(1, e, 0, 0, 0));
      for (int a = 0; a < x; a++) exp_q.push_back(mk(2, e, 0, 0, a));
      if (r > 0 && w > 0)
        for (int h = 0; h < r; h++)
          for (int k = 0; k < w; k++) exp_q.push_back(mk(2, e, 1, h, k));
      exp_q.push_back(mk(2, e, 2, 0, 0));
      exp_q.push_back(mk(3, e, 0, 0, 0));
      exp_q.push_back(mk(4, e, 0, 0, 0));
    end
    exp_q.push_back(mk(5, 0, 0, 0, 0));
  endtask

  task automatic drive_sizes(input int sx, input int sw, input int sl, input int sr);
    bus.SIZE_X_IN = CS'(sx);
    bus.SIZE_W_IN = CS'(sw);
    bus.SIZE_L_IN = CS'(sl);
    bus.SIZE_R_IN = CS'(sr);
  endtask

  // Returns at the falling edge of cycle 1 (START is high during cycle 0).
  task automatic start_layer(input int sx, input int sw, input int sl, input int sr);
    @(negedge clk);
    drive_sizes(sx, sw, sl, sr);
    bus.START = 1'b1;
    model_layer(sx, sw, sl, sr);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // A START the DUT must ignore because a layer is in flight.
  task automatic stray_start();
    @(negedge clk);
    drive_sizes(7, 7, 7, 7);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Ready-input driver.
  initial begin
    bus.OP_READY  = 1'b1;
    bus.ACT_READY = 1'b1;
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        bus.OP_READY  = 1'b1;
        bus.ACT_READY = 1'b1;
      end else if (mode == 1) begin
        bus.OP_READY  = 1'($urandom_range(0, 1));
        bus.ACT_READY = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: sampled just after the falling edge so inputs for the next rising edge are settled.
  initial begin
    ev_t         ev, ex;
    logic        prev_stall;
    logic [63:0] prev_vec, cur_vec;
    logic        have;
    prev_stall = 1'b0;
    prev_vec   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur_vec = {1'b0, bus.OP_ENABLE, bus.OP_SEL, bus.INDEX_L_OUT[11:0], bus.INDEX_I_OUT[23:0],
                   bus.INDEX_J_OUT[23:0]};
        if (prev_stall) check("stall_stable", cur_vec, prev_vec);
        prev_stall = bus.OP_ENABLE && !bus.OP_READY;
        prev_vec   = cur_vec;
        for (int s = 0; s < 5; s++) begin
          have = 1'b0;
          case (s)
            0: if (bus.ACC_CLEAR) begin
              have = 1'b1;
              ev = mk(1, int'(bus.INDEX_L_OUT[15:0]), 0, 0, 0);
            end
            1: if (bus.OP_ENABLE && bus.OP_READY) begin
              have = 1'b1;
              xfer_count++;
              ev = mk(2, int'(bus.INDEX_L_OUT[15:0]), int'(bus.OP_SEL),
                      int'(bus.INDEX_I_OUT[15:0]), int'(bus.INDEX_J_OUT[15:0]));
            end
            2: if (bus.ACT_ENABLE && bus.ACT_READY) begin
              have = 1'b1;
              ev = mk(3, int'(bus.INDEX_L_OUT[15:0]), 0, 0, 0);
            end
            3: if (bus.H_OUT_ENABLE) begin
              have = 1'b1;
              hout_count++;
              ev = mk(4, int'(bus.INDEX_L_OUT[15:0]), 0, 0, 0);
            end
            default: if (bus.READY) begin
              have = 1'b1;
              ev = mk(5, 0, 0, 0, 0);
            end
          endcase
          if (have) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_event: got %h expected none at %0t", ev, $time);
            end else begin
              ex = exp_q.pop_front();
              check("scoreboard", 64'(ev), 64'(ex));
            end
          end
        end
      end
    end
  end

  initial begin
    int n, cnt, h0, t0;
    logic [4:0] exp5;
    bus.START = 1'b0;
    drive_sizes(0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.READY, bus.ACC_CLEAR, bus.OP_ENABLE, bus.OP_SEL,
                                bus.ACT_ENABLE, bus.H_OUT_ENABLE, |bus.INDEX_L_OUT,
                                |bus.INDEX_I_OUT, |bus.INDEX_J_OUT}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run with cycle-exact timing.
    mode = 0;
    start_layer(2, 2, 2, 1);
    for (int c = 1; c <= 18; c++) begin
      check($sformatf("basic_timing_c%0d", c),
            64'({bus.ACC_CLEAR, bus.H_OUT_ENABLE, bus.READY}),
            64'({(c == 1 || c == 9), (c == 8 || c == 16), (c == 17)}));
      @(negedge clk);
    end
    wait_done("basic");

    // L = 0: READY in cycle 1, nothing else.
    start_layer(5, 5, 0, 5);
    check("l0_ready", 64'({bus.READY, bus.ACC_CLEAR, bus.OP_ENABLE}), 64'(3'b100));
    wait_done("l0");

    // X = 0, R = 0: CLEAR, BIAS, ACTIVATE, EMIT, READY.
    start_layer(0, 3, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      exp5 = 5'b10000 >> (c - 1);
      check($sformatf("x0r0_c%0d", c),
            64'({bus.ACC_CLEAR, bus.OP_ENABLE && bus.OP_SEL == 2'd2, bus.ACT_ENABLE,
                 bus.H_OUT_ENABLE, bus.READY}), 64'(exp5));
      @(negedge clk);
    end
    wait_done("x0r0");

    // Backpressure: each operand stalled for 4 cycles.
    mode = 2;
    bus.OP_READY  = 1'b0;
    bus.ACT_READY = 1'b1;
    t0 = xfer_count;
    start_layer(3, 2, 1, 0);
    for (int op = 0; op < 4; op++) begin
      n = 0;
      while (!bus.OP_ENABLE && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.OP_ENABLE) bound_fail("bp_wait_op");
      repeat (4) @(negedge clk);
      bus.OP_READY = 1'b1;
      @(negedge clk);
      bus.OP_READY = 1'b0;
    end
    wait_done("backpressure");
    check("bp_transfers", 64'(xfer_count - t0), 64'd4);
    mode = 0;

    // Size clamp plus an ignored START mid-run.
    h0 = hout_count;
    start_layer(0, 0, 100, 0);
    repeat (20) @(negedge clk);
    stray_start();
    wait_done("clamp");
    check("clamp_hout_count", 64'(hout_count - h0), 64'd64);

    // Activation stall: ACT_ENABLE held six cycles.
    mode = 2;
    bus.OP_READY  = 1'b1;
    bus.ACT_READY = 1'b0;
    start_layer(1, 0, 1, 0);
    n = 0;
    while (!bus.ACT_ENABLE && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ACT_ENABLE) bound_fail("act_wait");
    repeat (5) begin
      @(negedge clk);
      check("act_hold", 64'(bus.ACT_ENABLE), 64'd1);
    end
    bus.ACT_READY = 1'b1;
    @(negedge clk);
    bus.ACT_READY = 1'b0;
    check("act_then_emit", 64'({bus.ACT_ENABLE, bus.H_OUT_ENABLE}), 64'(2'b01));
    wait_done("act_stall");
    mode = 0;

    // Reset during the K*r phase of l = 1.
    start_layer(1, 2, 3, 2);
    n = 0;
    while (!(bus.OP_ENABLE && bus.OP_SEL == 2'd1 && bus.INDEX_L_OUT == CS'(1)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("midop_wait");
    #2;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midop_reset_outputs",
          64'({bus.READY, bus.ACC_CLEAR, bus.OP_ENABLE, bus.OP_SEL, bus.ACT_ENABLE,
               bus.H_OUT_ENABLE, |bus.INDEX_L_OUT, |bus.INDEX_I_OUT, |bus.INDEX_J_OUT}),
          64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_layer(1, 1, 2, 1);
    wait_done("restart");

    // START in the READY cycle begins the next layer.
    start_layer(1, 1, 1, 1);
    n = 0;
    while (!bus.READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.READY) bound_fail("b2b_wait_ready");
    drive_sizes(2, 0, 2, 0);
    bus.START = 1'b1;
    model_layer(2, 0, 2, 0);
    @(negedge clk);
    bus.START = 1'b0;
    wait_done("back_to_back");

    // Randomized layers with random handshakes.
    mode = 1;
    for (int t = 0; t < 25; t++) begin
      int sx, sw, sl, sr;
      sx = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(0, 5));
      sw = int'($urandom_range(0, 3));
      sl = int'($urandom_range(0, 3));
      sr = int'($urandom_range(0, 3));
      start_layer(sx, sw, sl, sr);
      if (sl > 0 && $urandom_range(0, 1) == 1) stray_start();
      wait_done($sformatf("random_%0d", t));
    end
    mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
